// File: rtl/timing_pkg.sv
// Shared encodings for the traffic-light timing path.
// Includes interval codes, programming selector codes and the countdown states.
package timing_pkg;

  typedef enum logic [1:0] {
    INT_BASE = 2'b00,
    INT_EXT  = 2'b01,
    INT_YEL  = 2'b10,
    INT_DBL  = 2'b11
  } interval_e;

  typedef enum logic [1:0] {
    SEL_BASE    = 2'b00,
    SEL_EXT     = 2'b01,
    SEL_YEL     = 2'b10,
    SEL_RESTORE = 2'b11
  } sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles.
// Asserting clear restarts the division from zero.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      cnt <= '0;
    else if (clear || tick)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/interval_timer.sv
// Timing-parameter store and seconds countdown for the light FSM.
// Resolves the requested interval to a length and flags expiry.
module interval_timer
  import timing_pkg::*;
#(
  parameter int unsigned VAL_W    = 4,
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned DEF_BASE = 6,
  parameter int unsigned DEF_EXT  = 3,
  parameter int unsigned DEF_YEL  = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Reset_Sync,
  input  logic             Prog_Sync,
  input  logic [1:0]       Time_Parameter_Selector,
  input  logic [VAL_W-1:0] Time_value,
  input  logic [1:0]       interval,
  input  logic             Start_Timer,
  output logic [VAL_W:0]   value,
  output logic [VAL_W:0]   remaining,
  output logic             Busy,
  output logic             Expired
);

  localparam logic [VAL_W-1:0] BASE_D = VAL_W'(DEF_BASE);
  localparam logic [VAL_W-1:0] EXT_D  = VAL_W'(DEF_EXT);
  localparam logic [VAL_W-1:0] YEL_D  = VAL_W'(DEF_YEL);
  localparam logic [VAL_W:0]   ONE    = {{VAL_W{1'b0}}, 1'b1};

  logic [VAL_W-1:0] t_base, t_ext, t_yel;
  logic [VAL_W:0]   cur_len;
  timer_state_e     state;
  logic             tick;
  logic             pre_clear;

  // Length from the parameter values held before any write in this cycle.
  always_comb begin
    cur_len = '0;
    case (interval_e'(interval))
      INT_BASE: cur_len = {1'b0, t_base};
      INT_EXT:  cur_len = {1'b0, t_ext};
      INT_YEL:  cur_len = {1'b0, t_yel};
      INT_DBL:  cur_len = {t_base, 1'b0};
      default:  cur_len = '0;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      t_base <= BASE_D;
      t_ext  <= EXT_D;
      t_yel  <= YEL_D;
    end else if (Reset_Sync) begin
      t_base <= BASE_D;
      t_ext  <= EXT_D;
      t_yel  <= YEL_D;
    end else if (Prog_Sync) begin
      case (sel_e'(Time_Parameter_Selector))
        SEL_BASE: if (Time_value != '0) t_base <= Time_value;
        SEL_EXT:  if (Time_value != '0) t_ext  <= Time_value;
        SEL_YEL:  if (Time_value != '0) t_yel  <= Time_value;
        SEL_RESTORE: begin
          t_base <= BASE_D;
          t_ext  <= EXT_D;
          t_yel  <= YEL_D;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      value <= {1'b0, BASE_D};
    else
      value <= cur_len;
  end

  assign pre_clear = Start_Timer || (state != RUN);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .Reset(Reset),
    .clear(pre_clear),
    .tick (tick)
  );

  // A start always wins over a coincident final tick: reload, no expiry.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      remaining <= '0;
      Busy      <= 1'b0;
      Expired   <= 1'b0;
    end else begin
      Expired <= 1'b0;
      if (Start_Timer) begin
        if (cur_len == '0) begin
          state     <= IDLE;
          remaining <= '0;
          Busy      <= 1'b0;
          Expired   <= 1'b1;
        end else begin
          state     <= RUN;
          remaining <= cur_len;
          Busy      <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            if (tick) begin
              if (remaining == ONE) begin
                state     <= IDLE;
                remaining <= '0;
                Busy      <= 1'b0;
                Expired   <= 1'b1;
              end else begin
                remaining <= remaining - ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
